// File: rtl/fp_accum_seq.sv
// fp_accum_seq: streaming FP32 accumulation sequencer that feeds an external
// combinational FP32 adder. It reduces each in_last-delimited vector to one sum.
// The optional denormal flush-to-zero on incoming elements is enabled by
// defining the macro FP_ACC_FTZ_EN.
module fp_accum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Element conditioning: optional flush of denormals to a signed zero.
  function automatic logic [31:0] cond(input logic [31:0] x);
`ifdef FP_ACC_FTZ_EN
    if (x[30:23] == 8'd0) begin
      return {x[31], 31'b0};
    end
    return x;
`else
    return x;
`endif
  endfunction

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  // A result waiting in HOLD only blocks input while the consumer stalls, so
  // a new vector head can enter in the same cycle the old sum is taken.
  assign in_ready = (state != HOLD) || out_ready;
  assign accept   = in_valid && in_ready;
  assign add_a    = acc;
  assign add_b    = cond(in_data);

  // Sequencer FSM: partial-sum register, beat counter and registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (state == HOLD && out_ready && !accept) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          if (accept) begin
            if (in_last) begin
              // Single-beat vector: no addition, the element is the sum.
              out_data  <= add_b;
              out_count <= {{(CNT_W-1){1'b0}}, 1'b1};
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              // First beat seeds the partial sum directly.
              acc       <= add_b;
              cnt       <= {{(CNT_W-1){1'b0}}, 1'b1};
              out_valid <= 1'b0;
              state     <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            if (in_last) begin
              out_data  <= add_sum;
              out_count <= sat_inc(cnt);
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= add_sum;
              cnt <= sat_inc(cnt);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with an ideal FP32 adder model on add_sum.
// A narrow counter (CNT_W=2) is used so saturation is reachable quickly.
module tb_fp_accum_seq;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;

  int compared   = 0;
  int mismatched = 0;

  fp_accum_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  // FP32 bit pattern to real (normals, zeros and denormals).
  function automatic real fp32_to_real(input logic [31:0] b);
    logic [63:0] d;
    real r;
    if (b[30:23] == 8'd0) begin
      r = $itor(b[22:0]) * (2.0 ** -149);
      return b[31] ? -r : r;
    end
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Real to FP32 with round-to-nearest-even (normal range).
  function automatic logic [31:0] real_to_fp32(input real r);
    logic [63:0] d;
    logic [30:0] em;
    logic        guard;
    logic        sticky;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'b0};
    em     = {8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    guard  = d[28];
    sticky = |d[27:0];
    if (guard && (sticky || em[0])) em = em + 31'd1;
    return {d[63], em};
  endfunction

  assign add_sum = real_to_fp32(fp32_to_real(add_a) + fp32_to_real(add_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_out_count", 32'(out_count), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1 + 2 + 3 = 6
    drive(1'b1, 32'h3F800000, 1'b0); tick;
    drive(1'b1, 32'h40000000, 1'b0); tick;
    check("v1_mid_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h40400000, 1'b1); tick;
    check("v1_valid", 32'(out_valid), 32'd1);
    check("v1_data",  out_data,       32'h40C00000);
    check("v1_count", 32'(out_count), 32'd3);
    drive(1'b0, 32'h0, 1'b0); tick;
    check("v1_drain", 32'(out_valid), 32'd0);

    // Single beat pi with consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h40490FDB, 1'b1); tick;
    check("pi_valid", 32'(out_valid), 32'd1);
    check("pi_data",  out_data,       32'h40490FDB);
    check("pi_count", 32'(out_count), 32'd1);

    // Stall for 5 cycles with a new head waiting
    drive(1'b1, 32'h3F800000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick;
      check("stall_data",  out_data,        32'h40490FDB);
      check("stall_valid", 32'(out_valid),  32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    tick;
    check("release_taken", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h40000000, 1'b1); tick;
    check("v3_data",  out_data,       32'h40400000);
    check("v3_count", 32'(out_count), 32'd2);

    // Back-to-back vectors {1,1} {2,2}
    drive(1'b1, 32'h3F800000, 1'b0); #1;
    check("b2b_rdy0", 32'(in_ready), 32'd1);
    tick;
    drive(1'b1, 32'h3F800000, 1'b1); tick;
    check("b2b_a_data",  out_data,       32'h40000000);
    check("b2b_a_count", 32'(out_count), 32'd2);
    drive(1'b1, 32'h40000000, 1'b0); #1;
    check("b2b_rdy2", 32'(in_ready), 32'd1);
    tick;
    check("b2b_gap_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h40000000, 1'b1); tick;
    check("b2b_b_valid", 32'(out_valid), 32'd1);
    check("b2b_b_data",  out_data,       32'h40800000);
    check("b2b_b_count", 32'(out_count), 32'd2);

    // clr after two of four elements
    drive(1'b1, 32'h40000000, 1'b0); tick;
    drive(1'b1, 32'h40000000, 1'b0); tick;
    drive(1'b0, 32'h0, 1'b0); clr = 1'b1; tick;
    clr = 1'b0;
    check("clr_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(1'b1, 32'h3F800000, 1'b1); tick;
    check("clr_next_data",  out_data,       32'h3F800000);
    check("clr_next_count", 32'(out_count), 32'd1);
    // clr while holding discards the result
    drive(1'b0, 32'h0, 1'b0); clr = 1'b1; tick;
    clr = 1'b0;
    check("clr_hold_valid", 32'(out_valid), 32'd0);
    #1;
    check("clr_hold_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Counter saturation: five ones, count sticks at 3
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h3F800000, i == 4); tick;
    end
    check("sat_data",  out_data,       32'h40A00000);
    check("sat_count", 32'(out_count), 32'd3);

    // Denormal input
    drive(1'b1, 32'h80000001, 1'b1); #1;
`ifdef FP_ACC_FTZ_EN
    check("ftz_add_b", add_b, 32'h80000000);
    tick;
    check("ftz_data", out_data, 32'h80000000);
`else
    check("ftz_add_b", add_b, 32'h80000001);
    tick;
    check("ftz_data", out_data, 32'h80000001);
`endif

    // Reset mid-vector
    drive(1'b1, 32'h40000000, 1'b0); tick;
    check("pre_rst_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    rst = 1'b1; #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_data",  out_data,       32'h0);
    tick;
    rst = 1'b0;
    drive(1'b1, 32'h3F800000, 1'b1); tick;
    check("post_rst_data",  out_data,       32'h3F800000);
    check("post_rst_count", 32'(out_count), 32'd1);
    drive(1'b0, 32'h0, 1'b0); tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
